handshake_pack_upsizer: RTL and testbench

- Downstream neighbour of the 32-bit ready-patted handshake stage.
- Consumes a 32-bit valid/ready beat stream, packs RATIO consecutive beats into one wide word and emits it through a registered (valid-patted) output.
- An input last flag closes a partial word early; a keep mask marks which lanes in the word are valid.
- Sustains one input beat per cycle when the downstream consumer is always ready.

---
 rtl/handshake_pack_upsizer_pkg.sv | 32 +++
 rtl/handshake_pack_upsizer_pack_out_slice.sv | 69 ++++++
 rtl/handshake_pack_upsizer.sv | 101 ++++++++++
 tb/tb_handshake_pack_upsizer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pack_upsizer_pkg.sv
// Shared constants and lane-decode helpers for the 32-bit beat packer.
package handshake_pack_upsizer_pkg;

  // Input beat width; fixed for the whole handshake chain.
  localparam int unsigned DATA_W    = 32;
  // Widest supported word, in beats; the helpers decode into this many lanes.
  localparam int unsigned MAX_RATIO = 16;
  localparam int unsigned MAX_CNT_W = $clog2(MAX_RATIO);

  typedef logic [MAX_RATIO-1:0] lane_vec_t;

  // Low (cnt+1) bits set: the lanes filled once beat number cnt is written.
  function automatic lane_vec_t keep_mask(input logic [MAX_CNT_W-1:0] cnt);
    lane_vec_t mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      mask[i] = (i <= 32'(cnt));
    end
    return mask;
  endfunction

  // One-hot lane select: the lane that beat number cnt is written into.
  function automatic lane_vec_t lane_sel(input logic [MAX_CNT_W-1:0] cnt);
    lane_vec_t sel;
    sel = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      sel[i] = (i == 32'(cnt));
    end
    return sel;
  endfunction

endpackage

// File: rtl/handshake_pack_upsizer_pack_out_slice.sv
// Registered output stage of the packer: holds the packed word, its keep
// mask and last flag, and the valid bit with load / hold / clear behaviour.
module pack_out_slice
  import handshake_pack_upsizer_pkg::*;
#(
  parameter int unsigned RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [DATA_W*RATIO-1:0] word_i,
  input  logic [RATIO-1:0]        keep_i,
  input  logic                    last_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [DATA_W*RATIO-1:0] data_o,
  output logic [RATIO-1:0]        keep_o,
  output logic                    last_o
);

  logic                    valid_q, valid_d;
  logic [DATA_W*RATIO-1:0] data_q, data_d;
  logic [RATIO-1:0]        keep_q, keep_d;
  logic                    last_q, last_d;

  // Next-state: a load wins over a clear, so a word taken in the same cycle a
  // new one closes is replaced without a bubble. load_i is only raised when
  // the upstream beat was accepted, which already implies the held word is
  // gone or absent, so the overwrite never loses a word.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = word_i;
      keep_d  = keep_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output registers; payload holds while the word waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/handshake_pack_upsizer.sv
// Packs RATIO consecutive 32-bit valid/ready beats into one wide word, lane 0
// first. s_last closes a partial word early; m_keep marks the filled lanes.
module handshake_pack_upsizer
  import handshake_pack_upsizer_pkg::*;
#(
  parameter int unsigned RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [DATA_W*RATIO-1:0] m_data,
  output logic [RATIO-1:0]        m_keep,
  output logic                    m_last,
  input  logic                    m_ready
);

  localparam int unsigned      CNT_W     = $clog2(RATIO);
  localparam int unsigned      WORD_W    = DATA_W * RATIO;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              s_fire;
  logic              closing;
  logic [RATIO-1:0]  lane_hit;
  logic [RATIO-1:0]  word_keep;
  logic [WORD_W-1:0] word;

  // Ready depends only on the output register state and the consumer, never
  // on s_valid, so there is no combinational loop through the upstream stage.
  assign s_ready = ~m_valid | m_ready;
  assign s_fire  = s_valid & s_ready;
  assign closing = (cnt_q == LAST_LANE) | s_last;

  assign lane_hit  = RATIO'(lane_sel(MAX_CNT_W'(cnt_q)));
  assign word_keep = RATIO'(keep_mask(MAX_CNT_W'(cnt_q)));

  // Word presented to the output slice: lanes below cnt from the
  // accumulator, lane cnt from the incoming beat, lanes above cnt zero.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (word_keep[k]) begin
        word[k*DATA_W +: DATA_W] = lane_hit[k] ? s_data : acc_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Packer next-state: fill one lane per non-closing beat, restart on close.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (s_fire) begin
      if (closing) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int unsigned k = 0; k < RATIO; k++) begin
          if (lane_hit[k]) begin
            acc_d[k*DATA_W +: DATA_W] = s_data;
          end
        end
      end
    end
  end

  // Packer state: beat counter and partial-word accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      // NOTE: the wide accumulator is reset on purpose: a reset mid-word must
      // discard the partial data, and the word mux never sees stale lanes.
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  pack_out_slice #(
    .RATIO (RATIO)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (s_fire & closing),
    .word_i  (word),
    .keep_i  (word_keep),
    .last_i  (s_last),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .keep_o  (m_keep),
    .last_o  (m_last)
  );

endmodule

// File: tb/tb_handshake_pack_upsizer.sv
// Self-checking bench for handshake_pack_upsizer with RATIO=4.
module tb_handshake_pack_upsizer;
  import handshake_pack_upsizer_pkg::*;

  localparam int unsigned RATIO  = 4;
  localparam int unsigned W      = DATA_W * RATIO;
  localparam int unsigned N_RAND = 10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              m_valid;
  logic [W-1:0]      m_data;
  logic [RATIO-1:0]  m_keep;
  logic              m_last;
  logic              m_ready;

  int n_checks = 0;
  int n_pass   = 0;

  // Random-phase scoreboard: accepted beats as {last, data}, oldest first.
  logic [DATA_W:0]   sb[$];
  int                sent;
  int                beats_out;
  int                cycles;
  logic              cur_v;
  logic              cur_l;
  logic [DATA_W-1:0] cur_d;
  logic              in_fire;
  logic              out_fire;

  always #5 clk = ~clk;

  handshake_pack_upsizer #(
    .RATIO (RATIO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_ready (m_ready)
  );

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  // Rebuild the expected word for the transfer about to happen from the
  // oldest scoreboard beats and compare it with the presented word.
  task automatic score_word();
    logic [W-1:0]     ed;
    logic [RATIO-1:0] ek;
    logic             el;
    logic [DATA_W:0]  b;
    ed = '0;
    ek = '0;
    el = 1'b0;
    for (int k = 0; k < RATIO; k++) begin
      check("rand_sb_avail", W'(sb.size() != 0), W'(1'b1));
      if (sb.size() == 0) break;
      b = sb.pop_front();
      ed[k*DATA_W +: DATA_W] = b[DATA_W-1:0];
      ek[k] = 1'b1;
      beats_out++;
      if (b[DATA_W]) begin
        el = 1'b1;
        break;
      end
    end
    check("rand_data", m_data, ed);
    check("rand_keep", W'(m_keep), W'(ek));
    check("rand_last", W'(m_last), W'(el));
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    drive(1'b0, '0, 1'b0);

    // ---- reset state ----
    #12;
    check("rst_m_valid", W'(m_valid), W'(1'b0));
    check("rst_m_data",  m_data,      W'(0));
    check("rst_m_keep",  W'(m_keep),  W'(0));
    check("rst_m_last",  W'(m_last),  W'(1'b0));
    check("rst_s_ready", W'(s_ready), W'(1'b1));
    #1 rst_n = 1'b1;
    tick();

    // ---- full-rate full words ----
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DATA_W'(32'h11 * (i + 1)), 1'b0);
      #1 check("full_s_ready", W'(s_ready), W'(1'b1));
      tick();
      check("full_m_valid", W'(m_valid), W'((i % 4) == 3));
      if (i == 3) begin
        check("full_w0_data", m_data, 128'h00000044_00000033_00000022_00000011);
        check("full_w0_keep", W'(m_keep), W'(4'hF));
        check("full_w0_last", W'(m_last), W'(1'b0));
      end
      if (i == 7) begin
        check("full_w1_data", m_data, 128'h00000088_00000077_00000066_00000055);
        check("full_w1_keep", W'(m_keep), W'(4'hF));
        check("full_w1_last", W'(m_last), W'(1'b0));
      end
    end
    drive(1'b0, '0, 1'b0);
    tick();
    check("full_idle_valid", W'(m_valid), W'(1'b0));

    // ---- partial close, then next beat lands in lane 0 ----
    drive(1'b1, 32'hA, 1'b0);
    tick();
    check("part_no_word", W'(m_valid), W'(1'b0));
    drive(1'b1, 32'hB, 1'b1);
    tick();
    check("part_valid", W'(m_valid), W'(1'b1));
    check("part_data",  m_data, 128'h00000000_00000000_0000000B_0000000A);
    check("part_keep",  W'(m_keep), W'(4'h3));
    check("part_last",  W'(m_last), W'(1'b1));
    drive(1'b1, 32'hC, 1'b1);
    tick();
    check("next_lane0_valid", W'(m_valid), W'(1'b1));
    check("next_lane0_data",  m_data, 128'h0000000C);
    check("next_lane0_keep",  W'(m_keep), W'(4'h1));

    // ---- single-beat packet ----
    drive(1'b1, 32'hDEADBEEF, 1'b1);
    tick();
    check("single_valid", W'(m_valid), W'(1'b1));
    check("single_data",  m_data, 128'hDEADBEEF);
    check("single_keep",  W'(m_keep), W'(4'h1));
    check("single_last",  W'(m_last), W'(1'b1));
    drive(1'b0, '0, 1'b0);
    tick();
    check("single_clear", W'(m_valid), W'(1'b0));

    // ---- back-pressure ----
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0);
      tick();
    end
    check("bp_valid", W'(m_valid), W'(1'b1));
    check("bp_data",  m_data, 128'h00000004_00000003_00000002_00000001);
    drive(1'b1, 32'h5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_s_ready_low", W'(s_ready), W'(1'b0));
      tick();
      check("bp_hold_valid", W'(m_valid), W'(1'b1));
      check("bp_hold_data",  m_data, 128'h00000004_00000003_00000002_00000001);
      check("bp_hold_keep",  W'(m_keep), W'(4'hF));
    end
    m_ready = 1'b1;
    #1 check("bp_release_ready", W'(s_ready), W'(1'b1));
    tick();
    check("bp_b2b_valid", W'(m_valid), W'(1'b1));
    check("bp_b2b_data",  m_data, 128'h00000005);
    check("bp_b2b_keep",  W'(m_keep), W'(4'h1));
    check("bp_b2b_last",  W'(m_last), W'(1'b1));
    drive(1'b0, '0, 1'b0);
    tick();
    check("bp_drain", W'(m_valid), W'(1'b0));

    // ---- reset mid-word ----
    drive(1'b1, 32'h100, 1'b0);
    tick();
    drive(1'b1, 32'h200, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", W'(m_valid), W'(1'b0));
    check("mid_rst_data",  m_data, W'(0));
    check("mid_rst_keep",  W'(m_keep), W'(0));
    check("mid_rst_last",  W'(m_last), W'(1'b0));
    #1 rst_n = 1'b1;
    tick();
    check("mid_rst_no_emit", W'(m_valid), W'(1'b0));
    drive(1'b1, 32'h300, 1'b1);
    tick();
    check("post_rst_valid", W'(m_valid), W'(1'b1));
    check("post_rst_data",  m_data, 128'h00000300);
    check("post_rst_keep",  W'(m_keep), W'(4'h1));
    drive(1'b0, '0, 1'b0);
    tick();

    // ---- random traffic against the scoreboard ----
    sent      = 0;
    beats_out = 0;
    cycles    = 0;
    cur_v     = 1'b0;
    cur_l     = 1'b0;
    cur_d     = '0;
    while (sent < N_RAND && cycles < 60000) begin
      if (!cur_v && $urandom_range(3) != 0) begin
        cur_v = 1'b1;
        cur_d = $urandom;
        cur_l = (sent == N_RAND - 1) || ($urandom_range(4) == 0);
      end
      drive(cur_v, cur_d, cur_l);
      m_ready = ($urandom_range(3) != 0);
      #1;
      in_fire  = s_valid & s_ready;
      out_fire = m_valid & m_ready;
      if (out_fire) score_word();
      if (in_fire) begin
        sb.push_back({cur_l, cur_d});
        sent++;
        cur_v = 1'b0;
      end
      tick();
      cycles++;
    end
    check("rand_all_sent", W'(sent), W'(N_RAND));
    drive(1'b0, '0, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m_valid & m_ready) score_word();
      tick();
    end
    check("rand_sb_empty",  W'(sb.size()), W'(0));
    check("rand_beats_out", W'(beats_out), W'(N_RAND));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
